// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues the EX/MEM load/store to the data cache, stalls the pipe
// until dhit, captures load/SC results and owns the LL/SC link register.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdat_i,
    input  logic              pipe_adv,
    input  logic              flush,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_busy,
    output logic [DATA_W-1:0] rdat_o,
    output logic              link_valid
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;

    logic is_req, is_store, is_load, is_ll, is_sc, sc_fail;
    logic complete, ll_set, link_clr;

    // dWEN_i wins if both request lines are ever high together.
    assign is_req   = dREN_i | dWEN_i;
    assign is_store = dWEN_i;
    assign is_load  = dREN_i & ~dWEN_i;
    assign is_ll    = is_load & ll_i;
    assign is_sc    = is_store & sc_i;
    assign sc_fail  = is_sc & ~(link_valid_q && (link_addr_q == addr_i));

    assign dmemaddr   = addr_i;
    assign dmemstore  = wdat_i;
    assign rdat_o     = rdat_q;
    assign link_valid = link_valid_q;

    always_comb begin
        state_d      = state_q;
        rdat_d       = rdat_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        dmemREN      = 1'b0;
        dmemWEN      = 1'b0;
        mem_busy     = 1'b0;
        complete     = 1'b0;
        ll_set       = 1'b0;
        link_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                // nRST gating keeps the request lines quiet while reset is held.
                if (nRST && is_req && !flush) begin
                    if (sc_fail) begin
                        rdat_d = '0;
                    end else begin
                        dmemREN  = is_load;
                        dmemWEN  = is_store;
                        mem_busy = 1'b1;
                        complete = dhit;
                        state_d  = dhit ? DONE : ACCESS;
                    end
                end
            end
            ACCESS: begin
                // flush is ignored here: the cache transaction must finish.
                dmemREN  = is_load;
                dmemWEN  = is_store;
                mem_busy = 1'b1;
                complete = dhit;
                if (dhit) state_d = DONE;
            end
            DONE: begin
                if (pipe_adv || flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (is_load)
                rdat_d = dmemload;
            else if (is_sc)
                rdat_d = {{(DATA_W-1){1'b0}}, 1'b1};
        end

        // A snoop only vetoes a completing LL when it hits the LL's own address.
        ll_set   = complete & is_ll & ~(snoop_inv && (snoop_addr == addr_i));
        link_clr = (complete & is_sc)
                 | (complete & is_store & (addr_i == link_addr_q))
                 | (snoop_inv & (snoop_addr == link_addr_q));

        if (ll_set) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_i;
        end else if (link_clr) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            rdat_q       <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            rdat_q       <= rdat_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

endmodule
